// File: rtl/fa_bist_pkg.sv
// Shared types and full-adder reference functions for the full-adder BIST sequencer.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int NUM_PATTERNS = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
  } fa_in_t;

  // Pattern index bit 2 drives a, bit 1 drives b, bit 0 drives cin.
  function automatic fa_in_t pattern_decode(input logic [2:0] p);
    fa_in_t v;
    v.a   = p[2];
    v.b   = p[1];
    v.cin = p[0];
    return v;
  endfunction

  // Returns {sum, cout} of a fault-free full adder.
  function automatic logic [1:0] fa_golden(input fa_in_t v);
    logic sum;
    logic cout;
    sum  = v.a ^ v.b ^ v.cin;
    cout = (v.a & v.b) | (v.a & v.cin) | (v.b & v.cin);
    return {sum, cout};
  endfunction

endpackage

// File: rtl/fa_bist_resp_cmp.sv
// Response checker: compares a captured CUT response with the golden full adder
// and accumulates the per-pattern fail map, saturating error count and first failure.
module fa_bist_resp_cmp
  import fa_bist_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             clr,
  input  logic [2:0]       p,
  input  logic             cut_sum,
  input  logic             cut_cout,
  output logic [7:0]       fail_map,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_idx
);

  logic [1:0] golden;
  logic       mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_comb begin
    golden   = fa_golden(pattern_decode(p));
    mismatch = ({cut_sum, cut_cout} != golden);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail_map         <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (cap && mismatch) begin
      fail_map[p] <= 1'b1;
      err_count   <= sat_inc(err_count);
      if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_idx   <= p;
      end
    end
  end

endmodule

// File: rtl/fa_bist_ctrl.sv
// BIST sequencer for a 1-bit full-adder cell: sweeps all 8 input patterns,
// waits a settle time per pattern and hands each response to the checker.
module fa_bist_ctrl
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             cut_a,
  output logic             cut_b,
  output logic             cut_cin,
  input  logic             cut_sum,
  input  logic             cut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass_ok,
  output logic [7:0]       fail_map,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_idx
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  state_t            state_q, state_d;
  logic [2:0]        p_q;
  logic [PASS_W-1:0] pass_q;
  logic [SET_W-1:0]  settle_q;
  fa_in_t            cut_q, cut_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_ok_q, pass_ok_d;
  logic              load_run, cap, advance, last;

  assign last = (p_q == 3'(NUM_PATTERNS - 1)) && (pass_q == PASS_W'(NUM_PASSES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_q == SET_W'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = last ? ST_DONE : ST_SETTLE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Abort overrides everything: CUT inputs drop to zero, pass_ok clears, results stay put.
  always_comb begin
    load_run  = (state_q == ST_IDLE) && start && !abort;
    cap       = (state_q == ST_CAPTURE) && !abort;
    advance   = cap && !last;
    busy_d    = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    done_d    = (state_q == ST_DONE) && !abort;
    pass_ok_d = pass_ok_q;
    cut_d     = cut_q;
    if (abort) begin
      pass_ok_d = 1'b0;
      cut_d     = '0;
    end else if (load_run) begin
      pass_ok_d = 1'b0;
      cut_d     = pattern_decode(3'd0);
    end else if (advance) begin
      cut_d = pattern_decode(p_q + 3'd1);
    end else if (state_q == ST_DONE) begin
      pass_ok_d = (err_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      pass_q    <= '0;
      settle_q  <= '0;
      cut_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_ok_q <= 1'b0;
    end else begin
      cut_q     <= cut_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_ok_q <= pass_ok_d;
      if (load_run) begin
        p_q      <= '0;
        pass_q   <= '0;
        settle_q <= SET_W'(SETTLE_CYCLES);
      end else if (advance) begin
        p_q      <= p_q + 3'd1;
        settle_q <= SET_W'(SETTLE_CYCLES);
        if (p_q == 3'(NUM_PATTERNS - 1)) pass_q <= pass_q + PASS_W'(1);
      end else if ((state_q == ST_SETTLE) && !abort) begin
        settle_q <= settle_q - SET_W'(1);
      end
    end
  end

  assign cut_a   = cut_q.a;
  assign cut_b   = cut_q.b;
  assign cut_cin = cut_q.cin;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass_ok = pass_ok_q;

  fa_bist_resp_cmp #(
    .ERR_W(ERR_W)
  ) u_resp_cmp (
    .clk              (clk),
    .rst              (rst),
    .cap              (cap),
    .clr              (load_run),
    .p                (p_q),
    .cut_sum          (cut_sum),
    .cut_cout         (cut_cout),
    .fail_map         (fail_map),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx)
  );

endmodule
